// File: rtl/mac_r4_pkg.sv
// Shared types and helpers for the radix-4 Booth iterative MAC.
package mac_r4_pkg;

    typedef enum logic [1:0] {IDLE, RUN, ACC} state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Unsigned operands need one extra digit to absorb the zero-extended top bits of b.
    function automatic int unsigned n_digits(input int unsigned width, input logic signed_mode);
        return signed_mode ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth encoder: 3-bit multiplier window to a {neg, one, two} digit.
module booth_r4_enc
    import mac_r4_pkg::*;
(
    input  logic [2:0]   win_i,
    output booth_digit_t dig_o
);

    always_comb begin
        dig_o     = '0;
        // 3'b111 is zero, so neg is masked there to avoid a spurious +1 carry-in.
        dig_o.neg = win_i[2] & ~(win_i[1] & win_i[0]);
        dig_o.one = win_i[1] ^ win_i[0];
        dig_o.two = (win_i == 3'b011) | (win_i == 3'b100);
    end

endmodule

// File: rtl/cla_add.sv
// Parametrised carry-lookahead adder built from 4-bit lookahead groups.
module cla_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] sum_o,
    output logic         co_o
);

    // Padding guarantees bit W exists, so its incoming carry is the carry-out.
    localparam int NG = W / 4 + 1;
    localparam int WP = 4 * NG;

    logic [WP-1:0] a_pad, b_pad, g, p, c, s;
    logic [NG:0]   cg;
    logic          unused_bits;

    assign a_pad = WP'(a_i);
    assign b_pad = WP'(b_i);
    assign g     = a_pad & b_pad;
    assign p     = a_pad ^ b_pad;
    assign cg[0] = ci_i;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            localparam int B = 4 * gi;
            assign c[B]   = cg[gi];
            assign c[B+1] = g[B] | (p[B] & cg[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & cg[gi]);
            assign cg[gi+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                            | (p[B+3] & p[B+2] & p[B+1] & g[B])
                            | (p[B+3] & p[B+2] & p[B+1] & p[B] & cg[gi]);
        end
    endgenerate

    assign s           = p ^ c;
    assign sum_o       = s[W-1:0];
    assign co_o        = c[W];
    assign unused_bits = ^{s[WP-1:W], cg[NG]};

endmodule

// File: rtl/mac_r4_iter.sv
// Iterative multiply-accumulate: one radix-4 Booth digit per clock, then one accumulate edge.
module mac_r4_iter
    import mac_r4_pkg::*;
#(
    parameter  int WIDTH = 256,
    parameter  int GUARD = 8,
    localparam int ACC_W = 2 * WIDTH + GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             acc_clear,
    output logic             out_valid,
    output logic [ACC_W-1:0] out,
    output logic             ovf
);

    localparam int PW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam int M  = ACC_W - 1;

    state_t           state_q;
    logic [PW-1:0]    a_sh_q, p_q, p_d;
    logic [BW-1:0]    b_sh_q;
    logic             b_prev_q;
    logic [CW-1:0]    rem_q;
    logic             sgn_q, clr_q;
    logic [ACC_W-1:0] out_q, out_d;
    logic             ovf_q, out_valid_q;

    logic             accept;
    booth_digit_t     dig;
    logic [PW-1:0]    pp_mag, pp_term;
    logic [ACC_W-1:0] base, addend;
    logic             acc_co, ovf_now;
    logic             unused_bits;

    assign in_ready  = ~rst & ((state_q == IDLE) | out_valid_q);
    assign accept    = in_valid & in_ready;
    assign out       = out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

    // Window {b[2i+1], b[2i], b[2i-1]}: b is shifted down two bits per digit.
    booth_r4_enc u_enc (
        .win_i ({b_sh_q[1:0], b_prev_q}),
        .dig_o (dig)
    );

    always_comb begin
        pp_mag = '0;
        if (dig.two)
            pp_mag = a_sh_q << 1;
        else if (dig.one)
            pp_mag = a_sh_q;
        pp_term = dig.neg ? ~pp_mag : pp_mag;
    end

    cla_add #(.W(PW)) u_pp_add (
        .a_i   (p_q),
        .b_i   (pp_term),
        .ci_i  (dig.neg),
        .sum_o (p_d),
        .co_o  ()
    );

    assign base   = clr_q ? '0 : out_q;
    assign addend = {{GUARD{sgn_q & p_q[2*WIDTH-1]}}, p_q[2*WIDTH-1:0]};

    cla_add #(.W(ACC_W)) u_acc_add (
        .a_i   (base),
        .b_i   (addend),
        .ci_i  (1'b0),
        .sum_o (out_d),
        .co_o  (acc_co)
    );

    assign ovf_now     = sgn_q ? ((base[M] == addend[M]) & (out_d[M] != base[M])) : acc_co;
    assign unused_bits = ^p_q[PW-1:2*WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            b_prev_q    <= 1'b0;
            p_q         <= '0;
            rem_q       <= '0;
            sgn_q       <= 1'b0;
            clr_q       <= 1'b0;
            out_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                RUN: begin
                    p_q      <= p_d;
                    a_sh_q   <= a_sh_q << 2;
                    b_sh_q   <= b_sh_q >> 2;
                    b_prev_q <= b_sh_q[1];
                    if (rem_q == '0)
                        state_q <= ACC;
                    else
                        rem_q <= rem_q - CW'(1);
                end
                ACC: begin
                    out_q       <= out_d;
                    out_valid_q <= 1'b1;
                    ovf_q       <= (ovf_q & ~clr_q) | ovf_now;
                    state_q     <= IDLE;
                end
                default: ;
            endcase
            // Accept overrides the state chosen above so a new op may start straight away.
            if (accept) begin
                state_q  <= RUN;
                a_sh_q   <= {{(PW-WIDTH){signed_mode & a[WIDTH-1]}}, a};
                b_sh_q   <= {{2{signed_mode & b[WIDTH-1]}}, b};
                b_prev_q <= 1'b0;
                p_q      <= '0;
                rem_q    <= CW'(n_digits(WIDTH, signed_mode) - 1);
                sgn_q    <= signed_mode;
                clr_q    <= acc_clear;
            end
        end
    end

endmodule
